// File: rtl/sprite_loader.sv
// sprite_loader: turns a header+pixel word stream into GPU sprite RAM writes.
// A burst is: start address word, (count-1) word, then count pixel words.
// Pixel writes can be restricted to the vertical sync window so that sprite
// memory never changes while the GPU is fetching pixels for display.
//
// Ports:
//   clk      system clock (GPU clock)
//   reset    synchronous active-high reset
//   s_data   stream word (address, count-1 or RGB444 pixel depending on state)
//   s_valid  s_data valid
//   s_ready  stream word accepted on a rising edge with s_valid && s_ready
//   v_sync   GPU vertical sync, same clock domain
//   wr_add   sprite RAM write address
//   wr_data  sprite RAM write data (RGB444)
//   wr_req   one-cycle write strobe
//   busy     burst in progress (state != S_ADDR)
//   done     one-cycle pulse alongside the last write of a burst
//   wrapped  sticky: current/last burst crossed the top RAM address
module sprite_loader #(
    parameter int unsigned ram_add_width    = 8,
    parameter bit          GATE_VBLANK      = 1'b1,
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     v_sync,
    output logic [ram_add_width-1:0] wr_add,
    output logic [11:0]              wr_data,
    output logic                     wr_req,
    output logic                     busy,
    output logic                     done,
    output logic                     wrapped
);

    localparam int unsigned AW = ram_add_width;

    // v_sync level that means "in vertical sync"
    localparam logic VS_ACTIVE = ~VSYNC_ACTIVE_LOW;

    typedef enum logic [1:0] {
        S_ADDR,
        S_LEN,
        S_DATA
    } state_t;

    state_t          state;
    logic [AW-1:0]   ptr;
    logic [AW-1:0]   rem;
    logic            first;
    logic            vs_q;
    logic            allow;
    logic            accept;

    // Upper stream bits carry no meaning in any state.
    logic unused_upper;
    assign unused_upper = ^s_data[15:12];

    assign allow   = !GATE_VBLANK || (vs_q == VS_ACTIVE);
    assign s_ready = !reset && ((state == S_ADDR) || (state == S_LEN) ||
                                ((state == S_DATA) && allow));
    assign accept  = s_valid && s_ready;

    // Burst FSM with registered write port and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_ADDR;
            ptr     <= '0;
            rem     <= '0;
            first   <= 1'b0;
            vs_q    <= ~VS_ACTIVE;
            wr_add  <= '0;
            wr_data <= '0;
            wr_req  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wrapped <= 1'b0;
        end else begin
            vs_q   <= v_sync;
            wr_req <= 1'b0;
            done   <= 1'b0;
            case (state)
                S_ADDR: begin
                    if (accept) begin
                        ptr     <= s_data[AW-1:0];
                        wrapped <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        rem   <= s_data[AW-1:0];
                        first <= 1'b1;
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        wr_req  <= 1'b1;
                        wr_add  <= ptr;
                        wr_data <= s_data[11:0];
                        ptr     <= ptr + AW'(1);
                        first   <= 1'b0;
                        // Address 0 reached by incrementing (not as the start
                        // address) means the burst rolled over the top.
                        if (!first && (ptr == '0)) begin
                            wrapped <= 1'b1;
                        end
                        if (rem == '0) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_ADDR;
                        end else begin
                            rem <= rem - AW'(1);
                        end
                    end
                end
                default: begin
                    state <= S_ADDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_loader.sv
// Scoreboard bench for sprite_loader: the driver pushes each expected RAM
// write when it issues a pixel word; a negedge monitor pops and compares on
// every wr_req, including the cycle distance from the previous write.
module tb_sprite_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        v_sync;
    logic [7:0]  wr_add;
    logic [11:0] wr_data;
    logic        wr_req;
    logic        busy;
    logic        done;
    logic        wrapped;

    sprite_loader #(
        .ram_add_width   (8),
        .GATE_VBLANK     (1'b1),
        .VSYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .s_data (s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .v_sync (v_sync),
        .wr_add (wr_add),
        .wr_data(wr_data),
        .wr_req (wr_req),
        .busy   (busy),
        .done   (done),
        .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  add;
        logic [11:0] data;
        logic        done;
        logic        wrapped;
        int          gap;     // expected cycles since previous write, 0 = don't care
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   last_wr = -100;
    int   wr_cnt  = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (wr_req) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got add 0x%0h data 0x%0h, expected no write",
                         wr_add, wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_add", 32'(wr_add), 32'(e.add));
                chk("wr_data", 32'(wr_data), 32'(e.data));
                chk("done", 32'(done), 32'(e.done));
                chk("wrapped", 32'(wrapped), 32'(e.wrapped));
                if (e.gap != 0) chk("write_gap", 32'(cyc - last_wr), 32'(e.gap));
            end
            last_wr = cyc;
        end else if (done) begin
            chk("done_without_wr_req", 32'(done), 32'd0);
        end
    end

    // Present one word (called at a negedge); returns at the negedge after acceptance.
    task automatic send(input logic [15:0] w);
        int n = 0;
        s_data  = w;
        s_valid = 1'b1;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word 0x%0h not accepted, expected accept within 200 cycles", w);
            s_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Header words carry junk in the upper bits, which must be ignored.
    task automatic hdr(input logic [7:0] a, input logic [7:0] len);
        send({8'hA5, a});
        send({8'h5A, len});
    endtask

    task automatic pix(input logic [11:0] d, input logic [7:0] a,
                       input logic dn, input logic wr, input int gap);
        exp_t e;
        e.add = a; e.data = d; e.done = dn; e.wrapped = wr; e.gap = gap;
        exp_q.push_back(e);
        send({4'hF, d});
    endtask

    task automatic push_exp(input logic [11:0] d, input logic [7:0] a, input logic dn);
        exp_t e;
        e.add = a; e.data = d; e.done = dn; e.wrapped = 1'b0; e.gap = 0;
        exp_q.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = 16'h0000;
        v_sync  = 1'b0;          // active (low) => writes allowed
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_wr_req", 32'(wr_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_add", 32'(wr_add), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        reset = 1'b0;
        #1;
        chk("idle_s_ready", 32'(s_ready), 32'd1);

        // Basic back-to-back burst
        hdr(8'h10, 8'h03);
        chk("basic_busy", 32'(busy), 32'd1);
        pix(12'hA01, 8'h10, 1'b0, 1'b0, 0);
        pix(12'hB02, 8'h11, 1'b0, 1'b0, 1);
        pix(12'hC03, 8'h12, 1'b0, 1'b0, 1);
        pix(12'hD04, 8'h13, 1'b1, 1'b0, 1);
        s_valid = 1'b0;
        chk("basic_busy_end", 32'(busy), 32'd0);

        // Vblank gating: v_sync high = outside vsync
        v_sync = 1'b1;
        repeat (2) @(negedge clk);
        hdr(8'h30, 8'h01);
        s_data  = 16'hF111;
        s_valid = 1'b1;
        push_exp(12'h111, 8'h30, 1'b0);
        chk("gate_busy", 32'(busy), 32'd1);
        repeat (3) begin
            chk("gate_stall_ready", 32'(s_ready), 32'd0);
            chk("gate_stall_wr", 32'(wr_req), 32'd0);
            @(negedge clk);
        end
        v_sync = 1'b0;
        @(negedge clk);
        chk("gate_open_ready", 32'(s_ready), 32'd1);
        chk("gate_open_wr", 32'(wr_req), 32'd0);
        v_sync = 1'b1;
        @(negedge clk);
        chk("gate_first_write", 32'(wr_req), 32'd1);
        s_data = 16'hF222;
        push_exp(12'h222, 8'h31, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("gate_restall_ready", 32'(s_ready), 32'd0);
            chk("gate_restall_wr", 32'(wr_req), 32'd0);
        end
        v_sync = 1'b0;
        @(negedge clk);
        chk("gate_resume_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        chk("gate_second_write", 32'(wr_req), 32'd1);
        s_valid = 1'b0;

        // Wrap across the top address
        hdr(8'hFE, 8'h03);
        pix(12'h001, 8'hFE, 1'b0, 1'b0, 0);
        pix(12'h002, 8'hFF, 1'b0, 1'b0, 1);
        pix(12'h003, 8'h00, 1'b0, 1'b1, 1);
        pix(12'h004, 8'h01, 1'b1, 1'b1, 1);
        s_valid = 1'b0;
        @(negedge clk);
        chk("wrap_sticky", 32'(wrapped), 32'd1);
        send(16'h0050);
        chk("wrap_cleared", 32'(wrapped), 32'd0);
        send(16'h0000);
        pix(12'h777, 8'h50, 1'b1, 1'b0, 0);
        s_valid = 1'b0;

        // Full RAM burst then an immediate 1-pixel burst
        @(negedge clk);
        hdr(8'h00, 8'hFF);
        for (int i = 0; i < 256; i++) begin
            pix(12'(i * 3 + 1), 8'(i), (i == 255), 1'b0, (i == 0) ? 0 : 1);
        end
        hdr(8'h40, 8'h00);
        pix(12'h123, 8'h40, 1'b1, 1'b0, 3);
        s_valid = 1'b0;

        // Reset in the middle of a 5-pixel burst
        @(negedge clk);
        hdr(8'h60, 8'h04);
        pix(12'hAAA, 8'h60, 1'b0, 1'b0, 0);
        pix(12'hBBB, 8'h61, 1'b0, 1'b0, 1);
        reset   = 1'b1;
        s_valid = 1'b0;
        #1;
        chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_wr_req", 32'(wr_req), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_wr_add", 32'(wr_add), 32'd0);
        chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
        @(negedge clk);
        hdr(8'h20, 8'h00);
        pix(12'h555, 8'h20, 1'b1, 1'b0, 0);
        s_valid = 1'b0;

        // s_valid gaps
        @(negedge clk);
        hdr(8'h70, 8'h02);
        pix(12'h0A0, 8'h70, 1'b0, 1'b0, 0);
        s_valid = 1'b0;
        @(negedge clk);
        pix(12'h0B0, 8'h71, 1'b0, 1'b0, 2);
        s_valid = 1'b0;
        @(negedge clk);
        pix(12'h0C0, 8'h72, 1'b1, 1'b0, 2);
        s_valid = 1'b0;

        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("total_writes", 32'(wr_cnt), 32'd274);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_loader.md
# sprite_loader

Stream-to-sprite-RAM writer that fills the GPU's sprite pixel memory through its `wr_add`/`wr_data`/`wr_req` write port. It takes a simple word stream (start address, length, pixel words) from the host-side interconnect and issues one RAM write per accepted pixel word. It watches the GPU's `v_sync` output so that, when gating is enabled, sprite memory is modified only during vertical sync and never while pixels are being fetched for display.

## Interface
- `ram_add_width`, 8, width of the sprite RAM address; must match the GPU instance.
- `GATE_VBLANK`, 1, 1 = pixel writes allowed only while `v_sync` is active; 0 = always allowed.
- `VSYNC_ACTIVE_LOW`, 1, polarity of the `v_sync` input (1 = active when low).

Ports:
- `clk`  in  1  system clock, the same clock as the GPU.
- `reset`  in  1  synchronous, active-high reset.
- `s_data`  in  16  stream word; meaning depends on state.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  word accepted on a rising edge where `s_valid && s_ready`.
- `v_sync`  in  1  GPU vertical sync output, same clock domain.
- `wr_add`  out  ram_add_width  sprite RAM write address, to GPU.
- `wr_data`  out  12  RGB444 pixel, to GPU.
- `wr_req`  out  1  one-cycle write strobe, to GPU.
- `busy`  out  1  high while a burst is in progress (state ≠ S_ADDR).
- `done`  out  1  one-cycle pulse when the last pixel of a burst is written.
- `wrapped`  out  1  sticky: the current or last burst crossed address 2^ram_add_width−1.

## Operation
- Three-state FSM:
  - **S_ADDR**: accept the start address from `s_data[ram_add_width-1:0]`, load the address pointer, clear `wrapped`, then go to S_LEN.
  - **S_LEN**: accept `count−1` from `s_data[ram_add_width-1:0]`, load the remaining counter, then go to S_DATA. Burst length is 1..2^ram_add_width.
  - **S_DATA**: each accepted word writes `s_data[11:0]` to the pointer. The pointer then increments modulo 2^ram_add_width. After the last word, return to S_ADDR.
- Unused upper bits of `s_data` are ignored in every state.
- `vs_q` is a one-flop registered copy of `v_sync`. `allow = !GATE_VBLANK || (vs_q == !VSYNC_ACTIVE_LOW)`.
- `s_ready` is combinational: `!reset && (state==S_ADDR || state==S_LEN || (state==S_DATA && allow))`.
- Wrap-around: if the pointer goes from all-ones to 0 while words remain, the write still happens at address 0 and `wrapped` is set. `wrapped` stays set until the next address word is accepted or reset.
- If `allow` drops mid-burst, the loader stalls in S_DATA with `s_ready` low. The stall holds the pointer and counter, and the burst resumes at the next active `v_sync`. Header words are never gated.
- Reset at any time, including mid-burst:
  - next state is S_ADDR, and the partial burst is discarded;
  - `wr_req`, `done`, `busy` and `wrapped` go to 0;
  - `wr_add` and `wr_data` go to 0;
  - `vs_q` goes to the inactive level.

## Timing
- Header words are accepted at one per cycle; S_ADDR to S_DATA takes a minimum of 2 cycles.
- Pixel write latency: a word accepted on edge N appears on `wr_add`/`wr_data` with `wr_req=1` during cycle N→N+1. All three outputs are registered.
- `wr_req` is high for exactly one cycle per accepted pixel. Back-to-back accepts give a continuous `wr_req`, so throughput is 1 pixel/clk.
- `wr_add`/`wr_data` hold their last values when `wr_req=0`.
- `done` is asserted in the same cycle as the final `wr_req`. `busy` falls on the same edge, and a new address word is accepted in that cycle.
- `v_sync` to `allow` latency: 1 cycle. A word accepted on the edge where `allow` falls is still written.
- `s_valid` gaps insert idle cycles with no `wr_req`. Nothing is lost or duplicated.

## Test plan
- Basic burst, GATE_VBLANK=0, `v_sync` held inactive: stream 0x10, 0x03, then 0xA01, 0xB02, 0xC03, 0xD04 with `s_valid` held high. Expect 4 consecutive `wr_req` cycles at addresses 0x10..0x13 with matching data, `done` on the 4th cycle, and `wrapped`=0.
- Vblank gating, GATE_VBLANK=1, VSYNC_ACTIVE_LOW=1: hold `v_sync`=1 and send a 2-pixel burst. Expect the header to be accepted and `s_ready`=0 in S_DATA with no `wr_req`. Drive `v_sync`=0: the first `wr_req` appears 2 cycles after the edge (1 cycle `vs_q` + 1 cycle register). Raise `v_sync` after one write: expect a stall, then resume on the next low phase with the second address.
- Wrap: start 0xFE, count−1 = 3. Expect writes at FE, FF, 00, 01, `wrapped`=1 from the write at 00 onward, and `wrapped` cleared when the next address word is accepted.
- Full RAM and back-to-back: start 0x00, count−1 = 0xFF, 256 pixels. Expect 256 contiguous `wr_req` cycles with `wrapped`=0. An immediate second 1-pixel burst (0x40, 0x00, 0x123) writes 0x123 to 0x40 with no gap beyond the 2 header cycles.
- Reset mid-burst: assert `reset` for 1 cycle after 2 of 5 pixels. Expect `wr_req`/`busy`/`done` to be 0 the next cycle and `s_ready`=0 during reset. A following stream of 0x20, 0x00, 0x555 is treated as a fresh header and writes 0x555 to 0x20.
- Valid gaps: toggle `s_valid` every other cycle during a 3-pixel burst. Expect exactly 3 single-cycle `wr_req` pulses separated by idle cycles, with correct sequential addresses.
